// File: rtl/rf_pkg.sv
// Shared widths and write-entry type for the 8x16 register file and its write-port arbiter.
package rf_pkg;

  localparam int RF_REGS = 8;
  localparam int RF_AW   = 3;
  localparam int RF_DW   = 16;

  typedef struct packed {
    logic             v;
    logic [RF_AW-1:0] regsel;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_wr_buf.sv
// One-entry writeback holding buffer with an age bit marking it younger than the other buffer.
module rf_wr_buf
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [RF_AW-1:0] reg_i,
  input  logic [RF_DW-1:0] data_i,
  input  logic             grant_i,
  input  logic             other_v_i,
  input  logic             other_grant_i,
  output rf_wr_t           ent_o,
  output logic             age_o
);

  rf_wr_t ent_q, ent_d;
  logic   age_q, age_d;

  always_comb begin
    ent_d = ent_q;
    age_d = age_q;
    if (load_i) begin
      ent_d = '{v: 1'b1, regsel: reg_i, data: data_i};
      // Younger only if the other entry survives this edge.
      age_d = other_v_i & ~other_grant_i;
    end else if (grant_i) begin
      ent_d.v = 1'b0;
      age_d   = 1'b0;
    end else if (other_grant_i) begin
      age_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent_q <= '0;
      age_q <= 1'b0;
    end else begin
      ent_q <= ent_d;
      age_q <= age_d;
    end
  end

  assign ent_o = ent_q;
  assign age_o = age_q;

endmodule

// File: rtl/rf_wr_arb.sv
// Age-ordered two-requester write-port arbiter for the 8x16 register file.
// Optional pending-write mask enabled by defining RF_WR_ARB_PEND_EN.
module rf_wr_arb
  import rf_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [RF_AW-1:0]   req0_reg,
  input  logic [RF_DW-1:0]   req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [RF_AW-1:0]   req1_reg,
  input  logic [RF_DW-1:0]   req1_data,
  output logic               req1_ready,
  output logic               write,
  output logic [RF_AW-1:0]   writeregsel,
  output logic [RF_DW-1:0]   writedata,
  output logic [RF_REGS-1:0] pend,
  output logic               busy
);

  rf_wr_t b0, b1;
  logic   age0, age1;
  logic   grant0, grant1, tie;
  logic   rr_q, rr_d;
  logic   write_q, write_d;
  logic [RF_AW-1:0] sel_q, sel_d;
  logic [RF_DW-1:0] data_q, data_d;

  assign req0_ready = ~b0.v | grant0;
  assign req1_ready = ~b1.v | grant1;

  rf_wr_buf u_buf0 (
    .clk(clk), .rst(rst),
    .load_i(req0_valid & req0_ready), .reg_i(req0_reg), .data_i(req0_data),
    .grant_i(grant0), .other_v_i(b1.v), .other_grant_i(grant1),
    .ent_o(b0), .age_o(age0)
  );

  rf_wr_buf u_buf1 (
    .clk(clk), .rst(rst),
    .load_i(req1_valid & req1_ready), .reg_i(req1_reg), .data_i(req1_data),
    .grant_i(grant1), .other_v_i(b0.v), .other_grant_i(grant0),
    .ent_o(b1), .age_o(age1)
  );

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    tie    = 1'b0;
    if (b0.v && b1.v) begin
      if (age0 != age1) begin
        grant0 = ~age0;
        grant1 = age0;
      end else begin
        tie    = 1'b1;
        grant0 = ~rr_q;
        grant1 = rr_q;
      end
    end else begin
      grant0 = b0.v;
      grant1 = b1.v;
    end
  end

  always_comb begin
    rr_d    = tie ? ~rr_q : rr_q;
    write_d = grant0 | grant1;
    sel_d   = sel_q;
    data_d  = data_q;
    if (grant0) begin
      sel_d  = b0.regsel;
      data_d = b0.data;
    end else if (grant1) begin
      sel_d  = b1.regsel;
      data_d = b1.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q    <= 1'b0;
      write_q <= 1'b0;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      rr_q    <= rr_d;
      write_q <= write_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
    end
  end

  assign write       = write_q;
  assign writeregsel = sel_q;
  assign writedata   = data_q;
  assign busy        = b0.v | b1.v | write_q;

`ifdef RF_WR_ARB_PEND_EN
  generate
    for (genvar gi = 0; gi < RF_REGS; gi++) begin : g_pend
      assign pend[gi] = (b0.v && b0.regsel == RF_AW'(gi)) ||
                        (b1.v && b1.regsel == RF_AW'(gi)) ||
                        (write_q && sel_q == RF_AW'(gi));
    end
  endgenerate
`else
  assign pend = '0;
`endif

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed self-checking bench for rf_wr_arb: reset, single write, ties, age order, streaming, mid-flight reset.
module tb_rf_wr_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_reg, req1_reg;
  logic [15:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        write;
  logic [2:0]  writeregsel;
  logic [15:0] writedata;
  logic [7:0]  pend;
  logic        busy;

  int total = 0;
  int bad   = 0;

`ifdef RF_WR_ARB_PEND_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  logic [18:0] wlog[$];
  logic [15:0] rf_m [8];

  always #5 clk = ~clk;

  rf_wr_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .write(write), .writeregsel(writeregsel), .writedata(writedata),
    .pend(pend), .busy(busy)
  );

  // Register-file model and retire log, sampled mid-cycle.
  always @(negedge clk) begin
    if (write) begin
      wlog.push_back({writeregsel, writedata});
      rf_m[writeregsel] = writedata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] exp5 [7];
    int sent, stalls, guard;
    bit r1_sent;
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0000;

    // Reset with a requester already asserting valid.
    rst = 1'b0; req0_valid = 1'b1; req0_reg = 3'd0; req0_data = 16'h0;
    req1_valid = 1'b0; req1_reg = 3'd0; req1_data = 16'h0;
    repeat (2) @(negedge clk);
    chk("rst_write", write, 0);
    chk("rst_sel", writeregsel, 0);
    chk("rst_data", writedata, 0);
    chk("rst_pend", pend, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1; req0_valid = 1'b0;
    @(negedge clk);
    chk("rst_rdy0", req0_ready, 1);
    chk("rst_rdy1", req1_ready, 1);
    chk("rst_nowrite", write, 0);

    // Single write r3 = BEEF.
    req0_valid = 1'b1; req0_reg = 3'd3; req0_data = 16'hBEEF;
    chk("t2_rdy", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("t2_pend_buf", pend, PE ? 8'h08 : 8'h00);
    chk("t2_busy_buf", busy, 1);
    chk("t2_write_early", write, 0);
    @(negedge clk);
    chk("t2_write", write, 1);
    chk("t2_sel", writeregsel, 3);
    chk("t2_data", writedata, 16'hBEEF);
    chk("t2_pend_wr", pend, PE ? 8'h08 : 8'h00);
    @(negedge clk);
    chk("t2_write_off", write, 0);
    chk("t2_busy_off", busy, 0);
    chk("t2_pend_off", pend, 0);
    chk("t2_hold_data", writedata, 16'hBEEF);

    // Same-edge tie twice: rr favours req0, then req1.
    for (int k = 0; k < 2; k++) begin
      req0_valid = 1'b1; req0_reg = 3'd1; req0_data = 16'h1111;
      req1_valid = 1'b1; req1_reg = 3'd2; req1_data = 16'h2222;
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk($sformatf("t3_rdy0_%0d", k), req0_ready, (k == 0) ? 1 : 0);
      chk($sformatf("t3_rdy1_%0d", k), req1_ready, (k == 1) ? 1 : 0);
      @(negedge clk);
      chk($sformatf("t3_first_%0d", k), {writeregsel, writedata}, (k == 0) ? {3'd1, 16'h1111} : {3'd2, 16'h2222});
      chk($sformatf("t3_w1_%0d", k), write, 1);
      @(negedge clk);
      chk($sformatf("t3_second_%0d", k), {writeregsel, writedata}, (k == 0) ? {3'd2, 16'h2222} : {3'd1, 16'h1111});
      chk($sformatf("t3_w2_%0d", k), write, 1);
      @(negedge clk);
      chk($sformatf("t3_idle_%0d", k), write, 0);
    end

    // Age order: r5 from req1 blocked, later r5 from req0 must retire after it.
    req0_valid = 1'b1; req0_reg = 3'd7; req0_data = 16'h0077;
    req1_valid = 1'b1; req1_reg = 3'd5; req1_data = 16'h0005;
    @(negedge clk);
    req1_valid = 1'b0;
    req0_reg = 3'd5; req0_data = 16'h0A05;
    chk("t4_rdy1_blocked", req1_ready, 0);
    chk("t4_rdy0", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("t4_w_r7", {write, writeregsel, writedata}, {1'b1, 3'd7, 16'h0077});
    chk("t4_rdy0_young", req0_ready, 0);
    @(negedge clk);
    chk("t4_w_old", {write, writeregsel, writedata}, {1'b1, 3'd5, 16'h0005});
    @(negedge clk);
    chk("t4_w_young", {write, writeregsel, writedata}, {1'b1, 3'd5, 16'h0A05});
    @(negedge clk);
    chk("t4_rf5", rf_m[5], 16'h0A05);

    // Streaming req0 with one req1 write; rr currently favours req1.
    wlog.delete();
    sent = 0; stalls = 0; guard = 0; r1_sent = 1'b0;
    while (sent < 6 && guard < 30) begin
      req0_valid = 1'b1; req0_reg = 3'(sent); req0_data = 16'(16'h5000 + sent);
      req1_valid = (sent == 2) && !r1_sent; req1_reg = 3'd6; req1_data = 16'h6666;
      #1;
      if (!req0_ready) stalls++;
      if (req1_valid && req1_ready) r1_sent = 1'b1;
      if (req0_ready) sent++;
      guard++;
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_sent", sent, 6);
    chk("t5_r1_sent", r1_sent, 1);
    chk("t5_stalls", stalls, 1);
    chk("t5_count", wlog.size(), 7);
    exp5 = '{{3'd0, 16'h5000}, {3'd1, 16'h5001}, {3'd6, 16'h6666}, {3'd2, 16'h5002},
             {3'd3, 16'h5003}, {3'd4, 16'h5004}, {3'd5, 16'h5005}};
    for (int i = 0; i < 7; i++)
      chk($sformatf("t5_entry%0d", i), (i < wlog.size()) ? wlog[i] : 19'h7FFFF, exp5[i]);

    // Reset while both buffers hold entries: nothing retires.
    req0_valid = 1'b1; req0_reg = 3'd0; req0_data = 16'hDEAD;
    req1_valid = 1'b1; req1_reg = 3'd4; req1_data = 16'hBEAD;
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t6_busy_pre", busy, 1);
    rst = 1'b0;
    wlog.delete();
    @(negedge clk);
    chk("t6_write", write, 0);
    chk("t6_busy", busy, 0);
    chk("t6_pend", pend, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_nolog", wlog.size(), 0);
    chk("t6_rf0", rf_m[0], 16'h5000);
    chk("t6_rf4", rf_m[4], 16'h5004);
    chk("t6_rdy0", req0_ready, 1);
    chk("t6_rdy1", req1_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
